// File: rtl/iecdrv_rom_slot_arb_if.sv
// Bus bundle between the multi-drive wrapper / shared ROM and the ROM slot arbiter.
// Latency: none (wires only).
// Backpressure: none; the arbiter is purely time-slotted.
// Ports (arbiter view, slave modport):
//   in : sync, drv_addr, drv_bank, overrun_clr, mem_q_std, mem_q_alt
//   out: mem_addr, drv_data, drv_valid, round_done, overrun
interface iecdrv_rom_slot_arb_if #(
    parameter int NDR    = 4,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic                  sync;
    logic [NDR*ADDR_W-1:0] drv_addr;
    logic [NDR-1:0]        drv_bank;
    logic                  overrun_clr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_q_std;
    logic [DATA_W-1:0]     mem_q_alt;
    logic [NDR*DATA_W-1:0] drv_data;
    logic [NDR-1:0]        drv_valid;
    logic                  round_done;
    logic                  overrun;

    // Wrapper + ROM side: drives requests and ROM read data.
    modport master (
        output sync, drv_addr, drv_bank, overrun_clr, mem_q_std, mem_q_alt,
        input  mem_addr, drv_data, drv_valid, round_done, overrun
    );

    // Arbiter side.
    modport slave (
        input  sync, drv_addr, drv_bank, overrun_clr, mem_q_std, mem_q_alt,
        output mem_addr, drv_data, drv_valid, round_done, overrun
    );
endinterface

// File: rtl/iecdrv_rom_slot_arb.sv
// Time-slotted arbiter: NDR drive CPUs share one ROM port, one slot per drive per sync round.
// Latency: slot i address issued i+1 edges after sync, data captured RD_LAT+1 edges later.
// Backpressure: none; a sync during a round restarts it and raises sticky overrun.
//
// Ports:
//   clk, reset_n  drive clock, async active-low reset (release expected synchronous upstream)
//   bus (slave)   sync/drv_addr/drv_bank/overrun_clr in, mem_addr out, mem_q_std/mem_q_alt in,
//                 drv_data/drv_valid/round_done/overrun out
// Parameters: NDR 1..8 slots, ADDR_W, DATA_W, RD_LAT 1..3 ROM read latency.
// Optional feature: define IECDRV_ROM_ARB_BANK_EN to let drv_bank[i] select mem_q_alt for slot i.
module iecdrv_rom_slot_arb #(
    parameter int NDR    = 4,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    iecdrv_rom_slot_arb_if.slave  bus
);
    localparam int LAST_CNT = NDR + RD_LAT;
    localparam int CNT_W    = $clog2(NDR + RD_LAT + 1);
    localparam int SLOT_W   = (NDR > 1) ? $clog2(NDR) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [NDR*DATA_W-1:0] drv_data_q;
    logic [NDR-1:0]        drv_valid_q;
    logic                  round_done_q;
    logic                  overrun_q;

    // Read pipeline travelling alongside the ROM access: stage 0 is loaded on the
    // address-issue edge, stage RD_LAT lines up with valid ROM data.
    logic [RD_LAT:0]       pipe_vld_q;
    logic [SLOT_W-1:0]     pipe_slot_q [RD_LAT+1];
`ifdef IECDRV_ROM_ARB_BANK_EN
    logic [RD_LAT:0]       pipe_bank_q;
    logic                  issue_bank_d;
`else
    logic                  unused_bank_inputs;
`endif

    logic                  running;
    logic                  last_edge;
    logic                  issue;
    logic [ADDR_W-1:0]     issue_addr_d;
    logic [DATA_W-1:0]     cap_dat_d;

    always_comb begin
        running      = (state_q == RUN);
        // Last edge of a round: the final slot's data is captured here.
        last_edge    = running && (cnt_q == CNT_W'(LAST_CNT));
        // No issue on a sync edge: the round restarts and anything issued now
        // would be flushed anyway.
        issue        = running && (cnt_q < CNT_W'(NDR)) && !bus.sync;
        issue_addr_d = '0;
        for (int i = 0; i < NDR; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                issue_addr_d = bus.drv_addr[i*ADDR_W +: ADDR_W];
            end
        end
`ifdef IECDRV_ROM_ARB_BANK_EN
        issue_bank_d = 1'b0;
        for (int i = 0; i < NDR; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                issue_bank_d = bus.drv_bank[i];
            end
        end
        cap_dat_d = pipe_bank_q[RD_LAT] ? bus.mem_q_alt : bus.mem_q_std;
`else
        cap_dat_d = bus.mem_q_std;
`endif
    end

`ifndef IECDRV_ROM_ARB_BANK_EN
    assign unused_bank_inputs = ^{bus.drv_bank, bus.mem_q_alt};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            drv_data_q   <= '0;
            drv_valid_q  <= '0;
            round_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            pipe_vld_q   <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                pipe_slot_q[k] <= '0;
            end
`ifdef IECDRV_ROM_ARB_BANK_EN
            pipe_bank_q  <= '0;
`endif
        end else begin
            // Read pipeline. On a sync, everything not yet at the last stage is
            // dropped so a restart can never route stale data to a slot; the
            // entry at the last stage still captures on this edge.
            pipe_vld_q[0]  <= issue;
            pipe_slot_q[0] <= SLOT_W'(cnt_q);
            for (int k = 1; k <= RD_LAT; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1] && !bus.sync;
                pipe_slot_q[k] <= pipe_slot_q[k-1];
            end
`ifdef IECDRV_ROM_ARB_BANK_EN
            pipe_bank_q <= {pipe_bank_q[RD_LAT-1:0], issue_bank_d};
`endif

            if (issue) begin
                mem_addr_q <= issue_addr_d;
            end

            drv_valid_q <= '0;
            if (pipe_vld_q[RD_LAT]) begin
                for (int i = 0; i < NDR; i++) begin
                    if (pipe_slot_q[RD_LAT] == SLOT_W'(i)) begin
                        drv_data_q[i*DATA_W +: DATA_W] <= cap_dat_d;
                        drv_valid_q[i]                 <= 1'b1;
                    end
                end
            end

            round_done_q <= last_edge;

            // A sync landing on the last edge is a clean back-to-back round, not
            // an overrun. Setting beats clearing.
            if (bus.sync && running && !last_edge) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.sync) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (bus.sync) begin
                        cnt_q <= '0;
                    end else if (last_edge) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.drv_data   = drv_data_q;
    assign bus.drv_valid  = drv_valid_q;
    assign bus.round_done = round_done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_iecdrv_rom_slot_arb.sv
// Bench for the ROM slot arbiter: a 4-slot/RD_LAT=1 instance driven by directed and random
// sync rounds against a slot-schedule model, plus a 2-slot/RD_LAT=3 instance for timing.
// ROM contents: std = addr[7:0], alt = ~addr[7:0].
module tb_iecdrv_rom_slot_arb;
    localparam int NDR     = 4;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 8;
    localparam int RD_LAT  = 1;
    localparam int NDR5    = 2;
    localparam int RD_LAT5 = 3;
`ifdef IECDRV_ROM_ARB_BANK_EN
    localparam bit BANK_EN = 1'b1;
`else
    localparam bit BANK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    iecdrv_rom_slot_arb_if #(.NDR(NDR),  .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    iecdrv_rom_slot_arb_if #(.NDR(NDR5), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus5 ();

    iecdrv_rom_slot_arb #(.NDR(NDR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    iecdrv_rom_slot_arb #(.NDR(NDR5), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .bus(bus5));

    // ROM models: RD_LAT register stages behind the registered address.
    logic [DATA_W-1:0] rom_std [RD_LAT];
    logic [DATA_W-1:0] rom_alt [RD_LAT];
    logic [DATA_W-1:0] rom5    [RD_LAT5];
    always @(posedge clk) begin
        rom_std[0] <= bus.mem_addr[7:0];
        rom_alt[0] <= ~bus.mem_addr[7:0];
        for (int k = 1; k < RD_LAT; k++) begin
            rom_std[k] <= rom_std[k-1];
            rom_alt[k] <= rom_alt[k-1];
        end
        rom5[0] <= bus5.mem_addr[7:0];
        for (int k = 1; k < RD_LAT5; k++) rom5[k] <= rom5[k-1];
    end
    assign bus.mem_q_std  = rom_std[RD_LAT-1];
    assign bus.mem_q_alt  = rom_alt[RD_LAT-1];
    assign bus5.mem_q_std = rom5[RD_LAT5-1];
    assign bus5.mem_q_alt = 8'h00;

    // Reference model: each slot has at most one scheduled capture (edge number, value).
    int                    n;
    int                    ev_edge [NDR];
    logic [DATA_W-1:0]     ev_val  [NDR];
    int                    done_edge;
    logic [NDR*DATA_W-1:0] m_data;
    logic [NDR-1:0]        m_valid;
    logic                  m_done;
    logic                  m_ovr;
    int                    checks = 0;
    int                    errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDR; i++) ev_edge[i] = -1;
        done_edge = -1;
        m_data    = '0;
        m_ovr     = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input logic sy, input logic clr,
                        input logic [NDR*ADDR_W-1:0] a, input logic [NDR-1:0] bk);
        logic pend;
        logic [ADDR_W-1:0] ai;
        bus.sync        = sy;
        bus.overrun_clr = clr;
        if (sy) begin
            bus.drv_addr = a;
            bus.drv_bank = bk;
        end
        @(posedge clk);
        n++;
        #1;
        m_valid = '0;
        m_done  = 1'b0;
        for (int i = 0; i < NDR; i++) begin
            if (ev_edge[i] == n) begin
                m_valid[i] = 1'b1;
                m_data[i*DATA_W +: DATA_W] = ev_val[i];
                ev_edge[i] = -1;
            end
        end
        if (done_edge == n) begin
            m_done    = 1'b1;
            done_edge = -1;
        end
        if (sy) begin
            pend = 1'b0;
            for (int i = 0; i < NDR; i++) if (ev_edge[i] > n) pend = 1'b1;
            if (pend) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
            for (int i = 0; i < NDR; i++) begin
                ai         = a[i*ADDR_W +: ADDR_W];
                ev_edge[i] = n + RD_LAT + 2 + i;
                ev_val[i]  = (BANK_EN && bk[i]) ? ~ai[7:0] : ai[7:0];
            end
            done_edge = n + RD_LAT + 1 + NDR;
        end else if (clr) begin
            m_ovr = 1'b0;
        end
        chk("drv_valid",  bus.drv_valid,  m_valid);
        chk("round_done", bus.round_done, m_done);
        chk("overrun",    bus.overrun,    m_ovr);
        chk("drv_data",   bus.drv_data,   m_data);
        bus.sync        = 1'b0;
        bus.overrun_clr = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [NDR*ADDR_W-1:0] a1, a2, a3, a4;
        logic [NDR*ADDR_W-1:0] ar;
        logic [NDR-1:0]        valid5_exp;
        bus.sync = 1'b0;  bus.overrun_clr = 1'b0;  bus.drv_addr = '0;  bus.drv_bank = '0;
        bus5.sync = 1'b0; bus5.overrun_clr = 1'b0; bus5.drv_addr = '0; bus5.drv_bank = '0;
        n = 0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_addr",   bus.mem_addr,    0);
        chk("rst_drv_data",   bus.drv_data,    0);
        chk("rst_drv_valid",  bus.drv_valid,   0);
        chk("rst_round_done", bus.round_done,  0);
        chk("rst_overrun",    bus.overrun,     0);
        chk("rst5_drv_data",  bus5.drv_data,   0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);

        // T1: single round
        a1 = {15'h403, 15'h302, 15'h201, 15'h100};
        step(1'b1, 1'b0, a1, 4'b0000);
        idle(8);
        chk("t1_data", bus.drv_data, 32'h03020100);

        // T2: resync at E+3 aborts slots 1..3 of the first round
        a2 = {15'h413, 15'h312, 15'h211, 15'h110};
        step(1'b1, 1'b0, a2, 4'b0000);
        idle(2);
        step(1'b1, 1'b0, a2, 4'b0000);
        chk("t2_partial_data", bus.drv_data, 32'h03020110);
        chk("t2_overrun_set",  bus.overrun,  1);
        idle(8);
        chk("t2_restart_data", bus.drv_data, 32'h13121110);
        step(1'b0, 1'b1, '0, '0);
        chk("t2_overrun_clr",  bus.overrun,  0);

        // T3: sync on the last capture edge is back-to-back, not an overrun
        a3 = {15'h423, 15'h322, 15'h221, 15'h120};
        step(1'b1, 1'b0, a3, 4'b0000);
        idle(5);
        step(1'b1, 1'b0, a2, 4'b0000);
        chk("t3_done",    bus.round_done, 1);
        chk("t3_overrun", bus.overrun,    0);
        idle(8);

        // Set-versus-clear on the same edge: set wins
        step(1'b1, 1'b0, a1, 4'b0000);
        idle(1);
        step(1'b1, 1'b1, a1, 4'b0000);
        chk("set_beats_clr", bus.overrun, 1);
        idle(8);
        step(1'b0, 1'b1, '0, '0);

        // T4: bank select
        a4 = {15'h3AA, 15'h2AA, 15'h1AA, 15'h0AA};
        step(1'b1, 1'b0, a4, 4'b0101);
        idle(8);
        chk("t4_bank_data", bus.drv_data, BANK_EN ? 32'hAA55AA55 : 32'hAAAAAAAA);

        // Random rounds, resyncs and clears
        for (int r = 0; r < 500; r++) begin
            for (int i = 0; i < NDR; i++) ar[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, ar, NDR'($urandom));
        end
        idle(8);
        step(1'b0, 1'b1, '0, '0);

        // T5: NDR=2, RD_LAT=3 timing on the second instance
        bus5.drv_addr = {15'h1CD, 15'h0AB};
        bus5.sync     = 1'b1;
        @(posedge clk);
        #1;
        bus5.sync = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            valid5_exp = (k == 5) ? 2'b01 : (k == 6) ? 2'b10 : 2'b00;
            chk($sformatf("t5_valid_e%0d", k), bus5.drv_valid,  valid5_exp);
            chk($sformatf("t5_done_e%0d",  k), bus5.round_done, k == 6);
        end
        chk("t5_data", bus5.drv_data, 16'hCDAB);
        chk("t5_ovr",  bus5.overrun,  0);

        // T6: async reset in the middle of an overrunning round
        step(1'b1, 1'b0, a2, 4'b0000);
        idle(1);
        step(1'b1, 1'b0, a3, 4'b0000);
        idle(2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_mem_addr",   bus.mem_addr,   0);
        chk("t6_drv_data",   bus.drv_data,   0);
        chk("t6_drv_valid",  bus.drv_valid,  0);
        chk("t6_round_done", bus.round_done, 0);
        chk("t6_overrun",    bus.overrun,    0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        idle(10);
        chk("t6_mem_addr_idle", bus.mem_addr, 0);
        step(1'b1, 1'b0, a1, 4'b0000);
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
